// File: rtl/fact_pkg.sv
// Shared definitions for the factorial accelerator: register offsets,
// FSM states and STATUS bit positions.
package fact_pkg;

  localparam logic [1:0] FACT_N      = 2'd0;
  localparam logic [1:0] FACT_GO     = 2'd1;
  localparam logic [1:0] FACT_STATUS = 2'd2;
  localparam logic [1:0] FACT_RESULT = 2'd3;

  localparam int DONE_BIT = 0;
  localparam int ERR_BIT  = 1;

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

endpackage

// File: rtl/fact_dp.sv
// Factorial datapath: down-counter, running product and the cnt<=1 test
// that tells the controller the product is complete.
module fact_dp #(
  parameter int W  = 32,
  parameter int NW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [NW-1:0] n,
  output logic [W-1:0]  prod,
  output logic          last
);

  logic [NW-1:0] cnt;

  // Multiply by the counter on the way down: n * (n-1) * ... * 2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      prod <= W'(1);
    end else if (load) begin
      cnt  <= n;
      prod <= W'(1);
    end else if (step) begin
      prod <= prod * W'(cnt);
      cnt  <= cnt - NW'(1);
    end
  end

  assign last = (cnt <= NW'(1));

endmodule

// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial accelerator with combinational read data.
// Define FACT_ACCEL_IRQ_EN to add a completion interrupt output (irq).
module fact_accel
  import fact_pkg::*;
#(
  parameter int W    = 32,
  parameter int NW   = 4,
  parameter int NMAX = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [1:0]   addr,
  input  logic [W-1:0] wd,
  output logic         busy,
`ifdef FACT_ACCEL_IRQ_EN
  output logic         irq,
`endif
  output logic [W-1:0] rd
);

  state_t        state, next_state;
  logic [NW-1:0] n_reg;
  logic          go_last;
  logic [W-1:0]  result;
  logic          done, err;

  logic          go_acc, go_err, load, step, finish, last;
  logic [W-1:0]  prod;

  fact_dp #(.W(W), .NW(NW)) u_dp (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .n    (n_reg),
    .prod (prod),
    .last (last)
  );

  assign go_acc = we && (addr == FACT_GO) && wd[0] && (state == IDLE);
  assign busy   = (state == CALC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    go_err     = 1'b0;
    case (state)
      IDLE: begin
        if (go_acc) begin
          if (n_reg > NW'(NMAX)) begin
            go_err = 1'b1;
          end else begin
            load       = 1'b1;
            next_state = CALC;
          end
        end
      end
      CALC: begin
        if (last) begin
          finish     = 1'b1;
          next_state = IDLE;
        end else begin
          step = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Completion flags are sticky; a new GO clears them before any re-set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg   <= '0;
      go_last <= 1'b0;
      result  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (we && (addr == FACT_N) && (state == IDLE))
        n_reg <= wd[NW-1:0];
      if (go_acc) begin
        go_last <= 1'b1;
        done    <= 1'b0;
        err     <= 1'b0;
      end
      if (go_err) begin
        err    <= 1'b1;
        done   <= 1'b1;
        result <= '0;
      end
      if (finish) begin
        result <= prod;
        done   <= 1'b1;
      end
    end
  end

`ifdef FACT_ACCEL_IRQ_EN
  // Raising wins over an acknowledge landing on the completion edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      irq <= 1'b0;
    else if (go_err || finish)
      irq <= 1'b1;
    else if ((we && (addr == FACT_STATUS)) || go_acc)
      irq <= 1'b0;
  end
`endif

  always_comb begin
    rd = '0;
    case (addr)
      FACT_N:      rd = W'(n_reg);
      FACT_GO:     rd = W'(go_last);
      FACT_STATUS: begin
        rd[DONE_BIT] = done;
        rd[ERR_BIT]  = err;
      end
      FACT_RESULT: rd = result;
      default:     rd = '0;
    endcase
  end

endmodule

// File: tb/tb_fact_accel.sv
// Randomized self-checking bench for fact_accel against a plain factorial model.
module tb_fact_accel;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic        busy;
  logic [31:0] rd;
`ifdef FACT_ACCEL_IRQ_EN
  logic        irq;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  fact_accel dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .addr (addr),
    .wd   (wd),
    .busy (busy),
`ifdef FACT_ACCEL_IRQ_EN
    .irq  (irq),
`endif
    .rd   (rd)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_fact(input int n);
    logic [31:0] f = 32'd1;
    for (int i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  task automatic readReg(input logic [1:0] a, output logic [31:0] v);
    we   = 1'b0;
    addr = a;
    #1;
    v = rd;
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    we   = 1'b1;
    addr = a;
    wd   = d;
    @(negedge clk);
    we   = 1'b0;
  endtask

  task automatic runCalc(input int n, input bit lockout);
    logic [31:0] v;
    bit          exp_err;
    int          exp_lat, k, busy_cnt;
    exp_err  = (n > 12);
    exp_lat  = exp_err ? 0 : ((n < 1) ? 1 : n);
    applyStimulus(2'd0, 32'(n));
    applyStimulus(2'd1, 32'd1);
    k        = 0;
    busy_cnt = 0;
    while (k <= 60) begin
      readReg(2'd2, v);
      if (busy) busy_cnt++;
      if (v[0]) break;
      if (lockout && k == 1) begin we = 1'b1; addr = 2'd0; wd = 32'd3; end
      if (lockout && k == 2) begin we = 1'b1; addr = 2'd1; wd = 32'd1; end
      @(negedge clk);
      k++;
    end
    checkOutput($sformatf("latency n=%0d", n), 32'(k), 32'(exp_lat));
    checkOutput($sformatf("busy cycles n=%0d", n), 32'(busy_cnt), 32'(exp_lat));
    checkOutput($sformatf("status n=%0d", n), v, exp_err ? 32'd3 : 32'd1);
    readReg(2'd3, v);
    checkOutput($sformatf("result n=%0d", n), v, exp_err ? 32'd0 : model_fact(n));
    readReg(2'd0, v);
    checkOutput($sformatf("n readback n=%0d", n), v, 32'(n));
  endtask

  initial begin
    logic [31:0] v, r_before, s_before;
    int          n;
    rst  = 1'b1;
    we   = 1'b0;
    addr = 2'd0;
    wd   = '0;
    #12;
    readReg(2'd0, v); checkOutput("reset N", v, 32'd0);
    readReg(2'd1, v); checkOutput("reset GO", v, 32'd0);
    readReg(2'd2, v); checkOutput("reset STATUS", v, 32'd0);
    readReg(2'd3, v); checkOutput("reset RESULT", v, 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    runCalc(5, 1'b0);
    readReg(2'd1, v); checkOutput("GO readback", v, 32'd1);
    runCalc(0, 1'b0);
    runCalc(1, 1'b0);
    runCalc(12, 1'b0);
    runCalc(13, 1'b0);
    checkOutput("busy after error", 32'(busy), 32'd0);
    runCalc(6, 1'b1);

    // GO with wd[0]=0 and writes to STATUS/RESULT must change nothing
    readReg(2'd3, r_before);
    readReg(2'd2, s_before);
    applyStimulus(2'd1, 32'hFFFF_FFFE);
    checkOutput("GO wd0=0 busy", 32'(busy), 32'd0);
    applyStimulus(2'd3, $urandom);
    applyStimulus(2'd2, $urandom);
    readReg(2'd3, v); checkOutput("RESULT write ignored", v, r_before);
    readReg(2'd2, v); checkOutput("STATUS write ignored", v, s_before);

    // Asynchronous reset in the middle of an n=10 run
    applyStimulus(2'd0, 32'd10);
    applyStimulus(2'd1, 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrun reset busy", 32'(busy), 32'd0);
    readReg(2'd2, v); checkOutput("midrun reset STATUS", v, 32'd0);
    readReg(2'd3, v); checkOutput("midrun reset RESULT", v, 32'd0);
    readReg(2'd0, v); checkOutput("midrun reset N", v, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    runCalc(3, 1'b0);

    for (int i = 0; i < 10; i++) begin
      n = int'($urandom_range(0, 15));
      runCalc(n, 1'b0);
    end

`ifdef FACT_ACCEL_IRQ_EN
    runCalc(4, 1'b0);
    checkOutput("irq on done", 32'(irq), 32'd1);
    applyStimulus(2'd2, 32'd0);
    checkOutput("irq after ack", 32'(irq), 32'd0);
    readReg(2'd2, v); checkOutput("done after ack", v, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
